// File: rtl/wb_spi_sram.sv
// ---------------------------------------------------------------------------
// wb_spi_sram
//   Wishbone B4 classic slave that turns single-byte bus reads and writes
//   into one complete SPI mode-0 frame on a 23LC1024-style serial SRAM:
//   8-bit command, 24-bit address, 8-bit data, MSB first. The SPI clock runs
//   at clk_i/2. A frame is never pipelined or overlapped with another frame.
//
// Ports
//   clk_i        clock, everything updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   wbs_cyc_i    Wishbone cycle
//   wbs_stb_i    Wishbone strobe
//   wbs_adr_i    byte address; the low 24 bits go on SPI
//   wbs_we_i     write enable
//   wbs_sel_i    byte select; a write with sel[0]=0 is answered with err
//   wbs_dat_i    write data
//   wbs_ack_o    acknowledge, single-cycle pulse
//   wbs_err_o    error, single-cycle pulse
//   wbs_rty_o    retry, constant 0
//   wbs_dat_o    read data, updated when a read frame completes
//   spi_sck_o    SPI clock, idles low
//   spi_cs_no    SPI chip select, active-low
//   spi_mosi_o   SPI serial data out
//   spi_miso_i   SPI serial data in
// ---------------------------------------------------------------------------
module wb_spi_sram #(
    parameter int         ADDR_WIDTH = 24,
    parameter int         DATA_WIDTH = 8,   // only 8 is supported
    parameter int         SEL_WIDTH  = DATA_WIDTH / 8,
    parameter logic [7:0] READ_CMD   = 8'h03,
    parameter logic [7:0] WRITE_CMD  = 8'h02
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic                  wbs_we_i,
    input  logic [SEL_WIDTH-1:0]  wbs_sel_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic                  wbs_rty_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  spi_sck_o,
    output logic                  spi_cs_no,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Edge counter value at the last edge of a frame (E80 is the 80th edge
    // after the start edge, counter runs 0..79).
    localparam logic [6:0] LAST_EDGE    = 7'd79;
    // First counter value at which MISO carries the data byte (bit 32).
    localparam logic [6:0] CAPTURE_FROM = 7'd64;

    // Address as it goes on the wire: low 24 bits, zero-extended if narrower.
    logic [23:0] adr24;

    generate
        if (ADDR_WIDTH >= 24) begin : g_adr_wide
            assign adr24 = wbs_adr_i[23:0];
            if (ADDR_WIDTH > 24) begin : g_adr_hi
                logic unused_adr_hi;
                assign unused_adr_hi = ^wbs_adr_i[ADDR_WIDTH-1:24];
            end
        end else begin : g_adr_narrow
            assign adr24 = {{(24 - ADDR_WIDTH){1'b0}}, wbs_adr_i};
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [6:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic                    sck_q, sck_d;
    logic                    cs_n_q, cs_n_d;
    logic                    mosi_q, mosi_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;

    // Pure datapath: no reset needed, always loaded before being used.
    logic [39:0]             shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;

    logic                    req;
    logic [39:0]             frame;

    // The !ack/!err qualifier stops a held strobe from re-triggering on the
    // cycle its response is visible.
    assign req   = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    assign frame = {(wbs_we_i ? WRITE_CMD : READ_CMD),
                    adr24,
                    (wbs_we_i ? wbs_dat_i[7:0] : 8'h00)};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        shreg_d = shreg_q;
        rx_d    = rx_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (wbs_we_i && !wbs_sel_i[0]) begin
                        // Write without its byte lane selected: refuse it
                        // without touching the device.
                        err_d = 1'b1;
                    end else begin
                        shreg_d = frame;
                        we_d    = wbs_we_i;
                        cs_n_d  = 1'b0;
                        mosi_d  = frame[39];
                        cnt_d   = 7'd0;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LAST_EDGE) begin
                    // End of frame. The device has seen all 40 bits, so the
                    // frame completes even if the master already left; only
                    // the ack depends on the cycle still being open.
                    sck_d   = 1'b0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = 7'd0;
                    state_d = DONE;
                    ack_d   = wbs_cyc_i;
                    if (!we_q) begin
                        dat_d = rx_q;
                    end
                end else if (!cnt_q[0]) begin
                    // Rising SCK: the device holds MISO stable here.
                    sck_d = 1'b1;
                    if (cnt_q >= CAPTURE_FROM) begin
                        rx_d = {rx_q[DATA_WIDTH-2:0], spi_miso_i};
                    end
                end else begin
                    // Falling SCK: present the next MOSI bit.
                    sck_d   = 1'b0;
                    shreg_d = shreg_q << 1;
                    mosi_d  = shreg_q[38];
                end
            end

            DONE: begin
                // One dead cycle keeps cs_n high for at least two clocks.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            we_q    <= 1'b0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shreg_q <= shreg_d;
        rx_q    <= rx_d;
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = err_q;
    assign wbs_rty_o  = 1'b0;
    assign wbs_dat_o  = dat_q;
    assign spi_sck_o  = sck_q;
    assign spi_cs_no  = cs_n_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_wb_spi_sram.sv
// ---------------------------------------------------------------------------
// tb_wb_spi_sram
//   Bench for wb_spi_sram: a behavioural SPI SRAM on the serial side, a
//   Wishbone master issuing directed and random accesses, a reference memory
//   that predicts every response, and monitors that pop the expected bus
//   responses and SPI frames from queues as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_wb_spi_sram;

    logic        clk;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic [23:0] adr;
    logic        we;
    logic [0:0]  sel;
    logic [7:0]  dat_w;
    logic        ack;
    logic        err;
    logic        rty;
    logic [7:0]  dat_r;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        miso;

    int total = 0;
    int bad   = 0;
    longint cyc_cnt = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] dat;
        longint     cyc;
    } resp_t;

    typedef struct {
        logic [39:0] bits;
        int          nbits;
        bit          chk_len;
    } frame_t;

    resp_t  exp_q[$];
    frame_t exp_frame_q[$];

    logic [7:0] ref_mem [logic [23:0]];
    logic [7:0] dev_mem [logic [23:0]];
    logic [7:0] exp_dato = 8'h00;

    wb_spi_sram dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_adr_i  (adr),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_err_o  (err),
        .wbs_rty_o  (rty),
        .wbs_dat_o  (dat_r),
        .spi_sck_o  (sck),
        .spi_cs_no  (cs_n),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [7:0] init_val(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [7:0] dev_rd(input logic [23:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return init_val(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural 23LC1024: samples MOSI on rising SCK, drives MISO after
    // falling SCK, commits a write only once all 40 bits have arrived.
    initial begin : spi_slave
        logic        prev_sck;
        logic        prev_cs;
        logic [39:0] bits;
        int          nbits;
        logic [7:0]  cmd;
        logic [7:0]  tmp;
        logic [23:0] raddr;
        time         t_fall;
        time         t_rise;
        bit          have_rise;
        frame_t      f;
        prev_sck  = 1'b0;
        prev_cs   = 1'b1;
        bits      = '0;
        nbits     = 0;
        cmd       = 8'h00;
        raddr     = '0;
        t_fall    = 0;
        t_rise    = 0;
        have_rise = 1'b0;
        miso      = 1'b0;
        forever begin
            @(sck or cs_n);
            if (prev_cs === 1'b1 && cs_n === 1'b0) begin
                nbits  = 0;
                bits   = '0;
                cmd    = 8'h00;
                t_fall = $time;
                if (have_rise) chk("cs_high_gap_ok", 64'(($time - t_rise) >= 20), 1);
            end
            if (prev_sck === 1'b0 && sck === 1'b1) begin
                if (cs_n === 1'b0) begin
                    bits = {bits[38:0], mosi};
                    nbits++;
                    if (nbits == 8)  cmd   = bits[7:0];
                    if (nbits == 32) raddr = bits[23:0];
                    if (nbits == 40 && cmd == 8'h02) dev_mem[raddr] = bits[7:0];
                end else begin
                    total++;
                    bad++;
                    $display("FAIL sck_idle actual=rising sck with cs_n high required=no sck");
                end
            end
            if (cs_n === 1'b0 && prev_sck === 1'b1 && sck === 1'b0 &&
                cmd == 8'h03 && nbits >= 32 && nbits < 40) begin
                tmp  = dev_rd(raddr);
                miso = tmp[39 - nbits];
            end
            if (prev_cs === 1'b0 && cs_n === 1'b1) begin
                miso      = 1'b0;
                t_rise    = $time;
                have_rise = 1'b1;
                if (exp_frame_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spi_frame actual=unexpected frame of %0d bits required=none", nbits);
                end else begin
                    f = exp_frame_q.pop_front();
                    chk("sck_rise_count", 64'(nbits), 64'(f.nbits));
                    chk("mosi_bits", bits, f.bits >> (40 - f.nbits));
                    if (f.chk_len) chk("cs_low_ns", 64'($time - t_fall), 800);
                end
            end
            prev_sck = sck;
            prev_cs  = cs_n;
        end
    end

    // Bus monitor: every ack/err pops one expected response.
    initial begin : bus_mon
        logic  prev_ack;
        resp_t r;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack || err) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL resp actual=unexpected ack=%0b err=%0b required=none", ack, err);
                    end else begin
                        r = exp_q.pop_front();
                        chk("resp_err", 64'(err), 64'(r.is_err));
                        chk("resp_ack", 64'(ack), 64'(!r.is_err));
                        chk("resp_dat_o", 64'(dat_r), 64'(r.dat));
                        chk("resp_cycle", cyc_cnt, r.cyc);
                        chk("rty", 64'(rty), 0);
                    end
                    if (ack) chk("ack_single_pulse", 64'(prev_ack), 0);
                end
                prev_ack = ack;
            end else begin
                prev_ack = 1'b0;
            end
        end
    end

    // Drive a request at the current (negedge) time and record what the DUT
    // must do with it. off = clocks until the start edge.
    task automatic issue(input bit w, input logic [23:0] a, input logic [7:0] d,
                         input bit s0, input int off, input bit want_ack);
        resp_t  r;
        frame_t f;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = a;
        dat_w = d;
        sel   = s0;
        if (w && !s0) begin
            r.is_err = 1'b1;
            r.dat    = exp_dato;
            r.cyc    = cyc_cnt + off;
            exp_q.push_back(r);
        end else begin
            f.bits    = {(w ? 8'h02 : 8'h03), a, (w ? d : 8'h00)};
            f.nbits   = 40;
            f.chk_len = 1'b1;
            exp_frame_q.push_back(f);
            if (w) ref_mem[a] = d;
            else   exp_dato = ref_rd(a);
            if (want_ack) begin
                r.is_err = 1'b0;
                r.dat    = exp_dato;
                r.cyc    = cyc_cnt + off + 80;
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic wait_resp(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ack || err) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s actual=no response in 200 cycles required=ack or err", name);
        end
    endtask

    task automatic wait_cs_high(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (cs_n) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s actual=cs_n still low after 200 cycles required=cs_n high", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic xfer(input bit w, input logic [23:0] a, input logic [7:0] d, input bit s0);
        @(negedge clk);
        issue(w, a, d, s0, 1, 1'b1);
        wait_resp("xfer");
        cyc = 1'b0;
        stb = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=simulation still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        frame_t      f;
        logic [23:0] pool [4];
        logic [23:0] a;
        bit          w;
        bit          s0;
        logic [7:0]  d;
        rst_n = 1'b1;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        sel   = 1'b1;
        adr   = '0;
        dat_w = '0;
        ref_mem[24'hFFFFFF] = 8'h3C;
        dev_mem[24'hFFFFFF] = 8'h3C;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(cs_n), 1);
        chk("rst_sck",  64'(sck), 0);
        chk("rst_mosi", 64'(mosi), 0);
        chk("rst_ack",  64'(ack), 0);
        chk("rst_err",  64'(err), 0);
        chk("rst_dat_o", 64'(dat_r), 0);
        chk("rst_rty",  64'(rty), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write, read of the top address, refused write.
        xfer(1'b1, 24'h012345, 8'hA5, 1'b1);
        xfer(1'b0, 24'hFFFFFF, 8'h00, 1'b1);
        xfer(1'b1, 24'h000777, 8'h11, 1'b0);
        repeat (5) @(negedge clk);

        // Master abandons a read around bit 10; the frame still completes.
        @(negedge clk);
        issue(1'b0, 24'h000100, 8'h00, 1'b1, 1, 1'b0);
        repeat (20) @(negedge clk);
        cyc = 1'b0;
        stb = 1'b0;
        wait_cs_high("drop_frame");
        xfer(1'b0, 24'h000000, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a write.
        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b1;
        sel   = 1'b1;
        adr   = 24'h0ABCDE;
        dat_w = 8'h77;
        f.bits    = {8'h02, 24'h0ABCDE, 8'h77};
        f.nbits   = 20;
        f.chk_len = 1'b0;
        exp_frame_q.push_back(f);
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", 64'(cs_n), 1);
        chk("midrst_sck",  64'(sck), 0);
        chk("midrst_ack",  64'(ack), 0);
        cyc      = 1'b0;
        stb      = 1'b0;
        we       = 1'b0;
        exp_dato = 8'h00;
        repeat (3) @(negedge clk);
        chk("midrst_dat_o", 64'(dat_r), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        xfer(1'b0, 24'h0ABCDE, 8'h00, 1'b1);
        xfer(1'b1, 24'h0ABCDE, 8'h42, 1'b1);
        xfer(1'b0, 24'h0ABCDE, 8'h00, 1'b1);

        // Back-to-back reads with the strobe held across the ack.
        @(negedge clk);
        issue(1'b0, 24'h012345, 8'h00, 1'b1, 1, 1'b1);
        wait_resp("b2b_first");
        issue(1'b0, 24'hFFFFFF, 8'h00, 1'b1, 2, 1'b1);
        wait_resp("b2b_second");
        cyc = 1'b0;
        stb = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic over a small address pool so reads hit earlier writes.
        pool[0] = 24'h000010;
        pool[1] = 24'h000011;
        pool[2] = 24'h800000;
        pool[3] = 24'hFFFFFE;
        for (int i = 0; i < 24; i++) begin
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 4) == 0) ? 24'($urandom) : pool[$urandom_range(0, 3)];
            d  = 8'($urandom);
            s0 = ($urandom_range(0, 5) != 0);
            xfer(w, a, d, s0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("resp_queue_empty",  64'(exp_q.size()), 0);
        chk("frame_queue_empty", 64'(exp_frame_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_spi_sram.md
Name: wb_spi_sram

Overview:
Wishbone B4 classic slave (responder) that turns single-byte bus reads and writes into SPI transactions on an external serial SRAM (23LC1024-style, SPI mode 0).
It sits on a slave port of the bus interconnect and serves the upper address region.
Each Wishbone access is one complete, non-pipelined SPI frame: command, 24-bit address, 8-bit data.

Parameters:
ADDR_WIDTH, 24, Wishbone address width; the low 24 bits go on SPI, zero-extended if narrower, upper bits ignored.
DATA_WIDTH, 8, Wishbone data width; only 8 is supported.
SEL_WIDTH, DATA_WIDTH/8, byte-select width.
READ_CMD, 8'h03, SPI read opcode.
WRITE_CMD, 8'h02, SPI write opcode.

Ports:
clk_i  in  1  clock; all logic rises on this edge
rst_ni  in  1  reset, asynchronous, active-low
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_adr_i  in  ADDR_WIDTH  byte address
wbs_we_i  in  1  write enable
wbs_sel_i  in  SEL_WIDTH  byte select
wbs_dat_i  in  DATA_WIDTH  write data
wbs_ack_o  out  1  acknowledge, one-cycle pulse
wbs_err_o  out  1  error, one-cycle pulse
wbs_rty_o  out  1  retry, tied 0
wbs_dat_o  out  DATA_WIDTH  read data
spi_sck_o  out  1  SPI clock, idle low
spi_cs_no  out  1  chip select, active-low
spi_mosi_o  out  1  serial data out, MSB first
spi_miso_i  in  1  serial data in

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - spi_cs_no=1, spi_sck_o=0, spi_mosi_o=0.
  - ack/err=0, wbs_dat_o=0, state IDLE, counters 0.
  - An aborted frame is never acked.
- Registered outputs: every output is registered, so none depends combinationally on inputs.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Request = cyc&stb&!ack_o&!err_o.
  - On a request with we=1 and sel[0]=0:
    - err_o=1 next cycle for one cycle.
    - No SPI activity; stay IDLE.
  - On any other request, sampled at edge E0:
    - Load a 40-bit shift register with {cmd, adr[23:0], we ? dat_i : 8'h00}.
    - spi_cs_no=0; spi_mosi_o=bit39; bit counter=0; go SHIFT.
  - The master's inputs are sampled only at E0. Later changes are ignored.
- SHIFT: SCK = clk/2, two phases per bit.
  - Phase 1 (odd edges E1, E3, ..., E79): sck->1; sample miso into the read-capture register.
  - Phase 0 (even edges E2, ..., E78): sck->0; shift register left; mosi = next bit.
  - Exactly 40 SCK rising edges per frame.
  - MISO is captured only on rising edges of bits 32..39, MSB first.
  - At E80: sck->0, cs_n->1, mosi->0, go DONE.
  - Also at E80: for reads, wbs_dat_o <= captured byte; for writes, wbs_dat_o keeps its previous value.
  - Also at E80: ack_o->1 iff cyc_i=1 at that edge.
- DONE:
  - At E81: ack_o->0, go IDLE.
  - Total latency from stb sampled to ack visible is 80 clocks. ack lasts exactly 1 clock.
  - cs_n stays high for at least 2 clocks between frames.
- cyc_i drop mid-frame: the SPI frame still runs to completion (the device is not left with a partial command); no ack is issued.
- Back-to-back: if stb is held after ack, the !ack_o qualifier blocks a double start at E81. A new frame may start at E82 at the earliest.
- wbs_rty_o is constant 0.

Test Plan:
- Write 8'hA5 to adr 24'h012345 -> MOSI bits = 02 01 23 45 A5 (40 bits, MSB first); cs_n low exactly 80 clocks; ack one pulse 80 clocks after stb; dat_o unchanged.
- Read adr 24'hFFFFFF with the SPI SRAM model returning 8'h3C -> MOSI = 03 FF FF FF 00; dat_o=8'h3C together with ack; exactly 40 SCK rising edges.
- Write with sel=0 -> err_o pulses 1 cycle the clock after stb; cs_n stays 1; ack never asserts.
- Drop cyc/stb at bit 10 of a read -> frame still finishes (cs_n high at E80), no ack; the next read of adr 0 returns the model data.
- Assert rst_ni low at E40 of a write -> cs_n=1, sck=0 immediately (asynchronously); ack stays 0; the next transaction completes normally.
- Two reads back-to-back, stb held high after ack -> second cs_n falling edge no earlier than 2 clocks after first rising edge; each read gets exactly one ack with correct data.
